p_reg_detect: RTL and testbench



---
 rtl/dsp48e1_pkg.sv | 23 ++
 rtl/pattern_detect_unit.sv | 42 ++++
 rtl/p_reg_detect.sv | 119 +++++++++++
 tb/tb_p_reg_detect.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dsp48e1_pkg.sv
// Shared constants for the DSP48E1 slice model: attribute strings and
// datapath defaults used by the P output stage and its helpers.
package dsp48e1_pkg;

   localparam int DSP_P_WIDTH = 48;
   localparam logic [DSP_P_WIDTH-1:0] DEFAULT_MASK = 48'h3FFF_FFFF_FFFF;

   localparam string PATDET_OFF = "NO_PATDET";
   localparam string PATDET_ON  = "PATDET";

   localparam string SEL_PATTERN_STATIC = "PATTERN";
   localparam string SEL_PATTERN_C      = "C";

   localparam string SEL_MASK_STATIC = "MASK";
   localparam string SEL_MASK_C      = "C";
   localparam string SEL_MASK_RM1    = "ROUNDING_MODE1";
   localparam string SEL_MASK_RM2    = "ROUNDING_MODE2";

   localparam string AUTORESET_NONE      = "NO_RESET";
   localparam string AUTORESET_MATCH     = "RESET_MATCH";
   localparam string AUTORESET_NOT_MATCH = "RESET_NOT_MATCH";

endpackage

// File: rtl/pattern_detect_unit.sv
// Combinational pattern/mask selection and masked match of the ALU result
// against the pattern and its complement.
module pattern_detect_unit
   import dsp48e1_pkg::*;
#(
   parameter int                  P_WIDTH     = DSP_P_WIDTH,
   parameter logic [P_WIDTH-1:0]  PATTERN     = '0,
   parameter logic [P_WIDTH-1:0]  MASK        = P_WIDTH'(DEFAULT_MASK),
   parameter string               SEL_PATTERN = SEL_PATTERN_STATIC,
   parameter string               SEL_MASK    = SEL_MASK_STATIC
) (
   input  logic [P_WIDTH-1:0] alu_out,
   input  logic [P_WIDTH-1:0] c,
   output logic               pd_d,
   output logic               pbd_d
);

   localparam bit PAT_FROM_C = (SEL_PATTERN == SEL_PATTERN_C);
   localparam bit MSK_FROM_C = (SEL_MASK == SEL_MASK_C);
   localparam bit MSK_RM1    = (SEL_MASK == SEL_MASK_RM1);
   localparam bit MSK_RM2    = (SEL_MASK == SEL_MASK_RM2);

   logic [P_WIDTH-1:0] pat;
   logic [P_WIDTH-1:0] msk;

   always_comb begin
      pat = PAT_FROM_C ? c : PATTERN;
      msk = MASK;
      if (MSK_FROM_C) begin
         msk = c;
      end else if (MSK_RM1) begin
         msk = {~c[P_WIDTH-2:0], 1'b0};
      end else if (MSK_RM2) begin
         msk = {~c[P_WIDTH-3:0], 2'b00};
      end
   end

   // A set mask bit forces that bit position to count as a match.
   assign pd_d  = &(~(alu_out ^ pat) | msk);
   assign pbd_d = &(~(alu_out ^ ~pat) | msk);

endmodule

// File: rtl/p_reg_detect.sv
// DSP48E1 output stage: P register, carry-out, P/PCOUT cascade, pattern
// detect with overflow/underflow history and auto-reset.
module p_reg_detect
   import dsp48e1_pkg::*;
#(
   parameter int                  P_WIDTH            = DSP_P_WIDTH,
   parameter int                  PREG               = 1,
   parameter string               USE_PATTERN_DETECT = PATDET_OFF,
   parameter logic [P_WIDTH-1:0]  PATTERN            = '0,
   parameter logic [P_WIDTH-1:0]  MASK               = P_WIDTH'(DEFAULT_MASK),
   parameter string               SEL_PATTERN        = SEL_PATTERN_STATIC,
   parameter string               SEL_MASK           = SEL_MASK_STATIC,
   parameter string               AUTORESET_PATDET   = AUTORESET_NONE
) (
   input  logic               clk,
   input  logic               rstp,
   input  logic               cep,
   input  logic [P_WIDTH-1:0] alu_out,
   input  logic [3:0]         alu_carry,
   input  logic [P_WIDTH-1:0] c,
   output logic [P_WIDTH-1:0] p,
   output logic [P_WIDTH-1:0] pcout,
   output logic [3:0]         carryout,
   output logic               carrycascout,
   output logic               patterndetect,
   output logic               patternbdetect,
   output logic               overflow,
   output logic               underflow
);

   localparam bit REG_EN    = (PREG == 1);
   localparam bit PATDET_EN = (USE_PATTERN_DETECT == PATDET_ON);
   localparam bit AR_MATCH  = (AUTORESET_PATDET == AUTORESET_MATCH);
   localparam bit AR_NMATCH = (AUTORESET_PATDET == AUTORESET_NOT_MATCH);

   logic               pd_d, pbd_d;
   logic               pd_en, pbd_en;
   logic [P_WIDTH-1:0] p_q;
   logic [3:0]         carry_q;
   logic               pd_q, pbd_q;
   logic               pd_past, pbd_past;
   logic               ar;

   pattern_detect_unit #(
      .P_WIDTH     (P_WIDTH),
      .PATTERN     (PATTERN),
      .MASK        (MASK),
      .SEL_PATTERN (SEL_PATTERN),
      .SEL_MASK    (SEL_MASK)
   ) u_pdu (
      .alu_out (alu_out),
      .c       (c),
      .pd_d    (pd_d),
      .pbd_d   (pbd_d)
   );

   assign pd_en  = pd_d & PATDET_EN;
   assign pbd_en = pbd_d & PATDET_EN;

   // Auto-reset looks only at registered flags, so it lands one cycle after
   // the triggering value has been visible on p.
   always_comb begin
      ar = 1'b0;
      if (REG_EN && PATDET_EN) begin
         if (AR_MATCH) begin
            ar = pd_q;
         end else if (AR_NMATCH) begin
            ar = pd_past & ~pd_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstp || ar) begin
         p_q     <= '0;
         carry_q <= '0;
         pd_q    <= 1'b0;
         pbd_q   <= 1'b0;
      end else if (cep) begin
         p_q     <= alu_out;
         carry_q <= alu_carry;
         pd_q    <= pd_en;
         pbd_q   <= pbd_en;
      end
   end

   // History flags survive auto-reset so overflow can still be reported.
   always_ff @(posedge clk) begin
      if (rstp) begin
         pd_past  <= 1'b0;
         pbd_past <= 1'b0;
      end else if (cep) begin
         pd_past  <= pd_q;
         pbd_past <= pbd_q;
      end
   end

   always_comb begin
      if (REG_EN) begin
         p              = p_q;
         carryout       = carry_q;
         patterndetect  = pd_q;
         patternbdetect = pbd_q;
         overflow       = pd_past & ~pd_q & ~pbd_q;
         underflow      = pbd_past & ~pd_q & ~pbd_q;
      end else begin
         p              = alu_out;
         carryout       = alu_carry;
         patterndetect  = pd_en;
         patternbdetect = pbd_en;
         overflow       = 1'b0;
         underflow      = 1'b0;
      end
   end

   assign pcout        = p;
   assign carrycascout = carryout[3];

endmodule

// File: tb/tb_p_reg_detect.sv
// Directed bench for p_reg_detect: several parameterisations share one
// stimulus stream; each check uses the instance whose setup it targets.
module tb_p_reg_detect;

   logic        clk = 1'b0;
   logic        rstp, cep;
   logic [47:0] alu_out, c;
   logic [3:0]  alu_carry;

   int total = 0;
   int bad   = 0;

   logic [47:0] exp_q[$];
   logic [47:0] exp_pd_q[$];

   // b: base (MASK=F), s: SEL_PATTERN=C, o: overflow (MASK=FF),
   // a: RESET_MATCH, m: PREG=0
   logic [47:0] p_b, pc_b, p_s, pc_s, p_o, pc_o, p_a, pc_a, p_m, pc_m;
   logic [3:0]  co_b, co_s, co_o, co_a, co_m;
   logic        cc_b, pd_b, pbd_b, ov_b, un_b;
   logic        cc_s, pd_s, pbd_s, ov_s, un_s;
   logic        cc_o, pd_o, pbd_o, ov_o, un_o;
   logic        cc_a, pd_a, pbd_a, ov_a, un_a;
   logic        cc_m, pd_m, pbd_m, ov_m, un_m;

   always #5 clk = ~clk;

   p_reg_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
                  .MASK(48'hF)) u_b (
      .clk(clk), .rstp(rstp), .cep(cep), .alu_out(alu_out), .alu_carry(alu_carry),
      .c(c), .p(p_b), .pcout(pc_b), .carryout(co_b), .carrycascout(cc_b),
      .patterndetect(pd_b), .patternbdetect(pbd_b), .overflow(ov_b), .underflow(un_b));

   p_reg_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .MASK(48'h0),
                  .SEL_PATTERN("C")) u_s (
      .clk(clk), .rstp(rstp), .cep(cep), .alu_out(alu_out), .alu_carry(alu_carry),
      .c(c), .p(p_s), .pcout(pc_s), .carryout(co_s), .carrycascout(cc_s),
      .patterndetect(pd_s), .patternbdetect(pbd_s), .overflow(ov_s), .underflow(un_s));

   p_reg_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
                  .MASK(48'hFF)) u_o (
      .clk(clk), .rstp(rstp), .cep(cep), .alu_out(alu_out), .alu_carry(alu_carry),
      .c(c), .p(p_o), .pcout(pc_o), .carryout(co_o), .carrycascout(cc_o),
      .patterndetect(pd_o), .patternbdetect(pbd_o), .overflow(ov_o), .underflow(un_o));

   p_reg_detect #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h9),
                  .MASK(48'h0), .AUTORESET_PATDET("RESET_MATCH")) u_a (
      .clk(clk), .rstp(rstp), .cep(cep), .alu_out(alu_out), .alu_carry(alu_carry),
      .c(c), .p(p_a), .pcout(pc_a), .carryout(co_a), .carrycascout(cc_a),
      .patterndetect(pd_a), .patternbdetect(pbd_a), .overflow(ov_a), .underflow(un_a));

   p_reg_detect #(.PREG(0), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
                  .MASK(48'hFF)) u_m (
      .clk(clk), .rstp(rstp), .cep(cep), .alu_out(alu_out), .alu_carry(alu_carry),
      .c(c), .p(p_m), .pcout(pc_m), .carryout(co_m), .carrycascout(cc_m),
      .patterndetect(pd_m), .patternbdetect(pbd_m), .overflow(ov_m), .underflow(un_m));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [47:0] ar_vals[4];
      ar_vals = '{48'd8, 48'd9, 48'd10, 48'd11};

      // reset with cep high: rstp wins
      rstp = 1'b1; cep = 1'b1; alu_out = 48'h1234; alu_carry = 4'b0; c = 48'h0;
      tick(); tick();
      check("rst_p", p_b, 48'h0);
      check("rst_pcout", pc_b, 48'h0);
      check("rst_carry", 48'(co_b), 48'h0);
      check("rst_flags", 48'({cc_b, pd_b, pbd_b, ov_b, un_b}), 48'h0);
      check("rst_comb_p", p_m, 48'h1234);
      rstp = 1'b0;
      tick();
      check("rel_p", p_b, 48'h1234);

      // latency and hold
      alu_out = 48'hABC; alu_carry = 4'b1000;
      tick();
      check("lat_p", p_b, 48'hABC);
      check("lat_pcout", pc_b, 48'hABC);
      check("lat_cascout", 48'(cc_b), 48'h1);
      cep = 1'b0; alu_out = 48'h5; alu_carry = 4'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_p", p_b, 48'hABC);
         check("hold_pcout", pc_b, 48'hABC);
         check("hold_cascout", 48'(cc_b), 48'h1);
      end

      // pattern detect
      cep = 1'b1; alu_out = 48'h7;
      tick();
      check("pd_hit", 48'(pd_b), 48'h1);
      check("pd_hit_pbd", 48'(pbd_b), 48'h0);
      alu_out = 48'hFFFF_FFFF_FFF3;
      tick();
      check("pbd_hit", 48'(pbd_b), 48'h1);
      check("pbd_hit_pd", 48'(pd_b), 48'h0);
      alu_out = 48'h17;
      tick();
      check("pd_miss", 48'(pd_b), 48'h0);
      c = 48'h55; alu_out = 48'h55;
      tick();
      check("pd_c_hit", 48'(pd_s), 48'h1);
      alu_out = 48'h54;
      tick();
      check("pd_c_miss", 48'(pd_s), 48'h0);

      // overflow / underflow after a fresh reset
      rstp = 1'b1;
      tick();
      rstp = 1'b0; alu_out = 48'hF0;
      tick();
      check("ov_first_pd", 48'(pd_o), 48'h1);
      check("ov_first", 48'(ov_o), 48'h0);
      check("comb_pd", 48'(pd_m), 48'h1);
      check("comb_p", p_m, 48'hF0);
      alu_out = 48'h100;
      tick();
      check("ov_set", 48'(ov_o), 48'h1);
      check("ov_set_un", 48'(un_o), 48'h0);
      check("comb_ov", 48'({ov_m, un_m}), 48'h0);
      tick();
      check("ov_once", 48'(ov_o), 48'h0);
      alu_out = 48'hFFFF_FFFF_FF10;
      tick();
      check("un_first_pbd", 48'(pbd_o), 48'h1);
      check("un_first", 48'(un_o), 48'h0);
      alu_out = 48'hFFFF_FFFF_FEFF;
      tick();
      check("un_set", 48'(un_o), 48'h1);
      check("un_set_ov", 48'(ov_o), 48'h0);
      check("comb_un", 48'({ov_m, un_m}), 48'h0);
      check("comb_p2", p_m, 48'hFFFF_FFFF_FEFF);
      cep = 1'b0;
      tick();
      check("un_persist", 48'(un_o), 48'h1);
      cep = 1'b1;

      // auto-reset on match: 9 is shown for one cycle, then cleared
      rstp = 1'b1;
      tick();
      rstp = 1'b0;
      exp_q    = '{48'd8, 48'd9, 48'd0, 48'd11};
      exp_pd_q = '{48'd0, 48'd1, 48'd0, 48'd0};
      for (int i = 0; i < 4; i++) begin
         alu_out = ar_vals[i];
         tick();
         check("ar_p", p_a, exp_q.pop_front());
         check("ar_pd", 48'(pd_a), exp_pd_q.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
